// File: rtl/priority_scan_encoder_if.sv
// Request-in / index-out bundle for the priority scan encoder.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the beat side.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             in_lsb_first;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_idx;
  logic             out_last;
  logic [IDX_W:0]   out_count;
  logic             busy;

  // Producer of requests / consumer of beats.
  modport master (
    output in_valid, in_vec, in_lsb_first, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_count, busy
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, in_lsb_first, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_count, busy
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Emits the index of every set bit of a captured request vector, one per beat, MSB- or LSB-first.
// Latency: first beat one cycle after capture, then 1 beat/cycle; one bubble cycle between vectors.
// Backpressure: beats hold stable while out_ready is low; in_ready is low for the whole scan.
module priority_scan_encoder #(
  parameter int               WIDTH      = 16,
  parameter int               IDX_W      = $clog2(WIDTH),
  parameter int               OUT_W      = 8,
  parameter logic [OUT_W-1:0] EMPTY_CODE = 8'hF0
) (
  input logic                  clk,
  input logic                  rst,
  priority_scan_encoder_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;      // bits not yet retired, including the one on out_idx
  logic             lsb_q, lsb_d;        // scan order, frozen for the whole vector
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [WIDTH-1:0] rem;                 // working vector after retiring the current bit

  // Position of the highest (msb order) or lowest (lsb order) set bit; 0 for an empty vector.
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v, input logic lsb);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lsb) begin
        if (v[WIDTH-1-i]) r = IDX_W'(WIDTH-1-i);
      end else begin
        if (v[i]) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction

  // True when exactly one bit is set.
  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Output code for a working vector: zero-extended index, or the empty marker.
  function automatic logic [OUT_W-1:0] present(input logic [WIDTH-1:0] v, input logic lsb);
    if (v == '0) return EMPTY_CODE;
    return OUT_W'(pick(v, lsb));
  endfunction

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_count = count_q;

  // Next-state and datapath: capture in IDLE, retire one bit per accepted beat in SCAN.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    lsb_d       = lsb_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    last_d      = last_q;
    count_d     = count_q;
    rem         = work_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << pick(work_q, lsb_q));

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d      = bus.in_vec;
          lsb_d       = bus.in_lsb_first;
          count_d     = popcount(bus.in_vec);
          out_valid_d = 1'b1;
          idx_d       = present(bus.in_vec, bus.in_lsb_first);
          // An empty vector still produces one (final) beat.
          last_d      = (bus.in_vec == '0) || one_hot(bus.in_vec);
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (out_valid_q && bus.out_ready) begin
          if (last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            work_d      = '0;
          end else begin
            work_d = rem;
            idx_d  = present(rem, lsb_q);
            last_d = one_hot(rem);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      lsb_q       <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= EMPTY_CODE;
      last_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      lsb_q       <= lsb_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboarded bench for priority_scan_encoder: directed cases plus randomized vectors.
// Expected beats are the set-bit positions listed in scan order by the bench itself.
// A negedge monitor pops and compares every accepted beat and checks hold/bubble rules.
module tb_priority_scan_encoder;

  localparam logic [7:0] EMPTY = 8'hF0;

  typedef struct packed {
    logic [7:0] idx;
    logic       last;
    logic [4:0] cnt;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  priority_scan_encoder_if #(.WIDTH(16), .OUT_W(8)) bus ();
  priority_scan_encoder_if #(.WIDTH(32), .OUT_W(8)) bus32 ();

  priority_scan_encoder #(.WIDTH(16), .OUT_W(8), .EMPTY_CODE(8'hF0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  priority_scan_encoder #(.WIDTH(32), .OUT_W(8), .EMPTY_CODE(8'hF0)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_ready = 1'b0;

  // Monitor state.
  beat_t      mon_b;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_idx;
  logic       prev_last;
  logic       pend_idle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the set bits in the requested order; an empty vector is one marker beat.
  task automatic push_model(input logic [15:0] v, input bit lsb);
    int    c;
    int    seen;
    int    pos;
    beat_t b;
    c = 0;
    seen = 0;
    for (int i = 0; i < 16; i++) if (v[i]) c++;
    if (c == 0) begin
      b.idx = EMPTY; b.last = 1'b1; b.cnt = 5'd0;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < 16; k++) begin
        pos = lsb ? k : 15 - k;
        if (v[pos]) begin
          seen++;
          b.idx  = 8'(pos);
          b.last = (seen == c);
          b.cnt  = 5'(c);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Offer one vector, wait for capture, register expectations, check first-beat latency.
  task automatic send_vec(input logic [15:0] v, input bit lsb);
    int t;
    t = 0;
    while (!bus.in_ready && t < 400) begin
      tick();
      t++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    check("out_valid_idle", bus.out_valid, 0);
    bus.in_valid     = 1'b1;
    bus.in_vec       = v;
    bus.in_lsb_first = lsb;
    tick();
    push_model(v, lsb);
    bus.in_valid     = 1'b0;
    bus.in_lsb_first = ~lsb;            // must not affect the running scan
    bus.in_vec       = 16'($urandom);
    check("first_beat_latency", bus.out_valid, 1);
    check("out_count", bus.out_count, $countones(v));
    check("busy_in_scan", bus.busy, 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && t < 600) begin
      tick();
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_in_ready", bus.in_ready, 1);
  endtask

  // Random consumer backpressure.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare accepted beats, check holds under stall and the post-vector bubble.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      pend_idle  = 1'b0;
    end else begin
      if (pend_idle) begin
        check("bubble_in_ready", bus.in_ready, 1);
        check("bubble_out_valid", bus.out_valid, 0);
        pend_idle = 1'b0;
      end
      if (prev_stall) begin
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_out_idx", bus.out_idx, prev_idx);
        check("hold_out_last", bus.out_last, prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got idx %0h, expected no beat", bus.out_idx);
        end else begin
          mon_b = exp_q.pop_front();
          check("beat_idx", bus.out_idx, mon_b.idx);
          check("beat_last", bus.out_last, mon_b.last);
          check("beat_count", bus.out_count, mon_b.cnt);
          if (mon_b.last) pend_idle = 1'b1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_idx   = bus.out_idx;
      prev_last  = bus.out_last;
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int          sel;

    bus.in_valid       = 1'b0;
    bus.in_vec         = '0;
    bus.in_lsb_first   = 1'b0;
    bus.out_ready      = 1'b1;
    bus32.in_valid     = 1'b0;
    bus32.in_vec       = '0;
    bus32.in_lsb_first = 1'b0;
    bus32.out_ready    = 1'b1;
    rst = 1'b1;
    #2;
    // Reset values.
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, EMPTY);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: two bits, MSB-first; out_count persists after the scan.
    send_vec(16'h8001, 1'b0);
    check("t1_first_idx", bus.out_idx, 15);
    wait_drain();
    check("t1_count_held", bus.out_count, 2);

    // 2: same vector, LSB-first.
    send_vec(16'h8001, 1'b1);
    check("t2_first_idx", bus.out_idx, 0);
    wait_drain();

    // 3: empty vector.
    send_vec(16'h0000, 1'b0);
    check("t3_last", bus.out_last, 1);
    wait_drain();

    // 4: backpressure on the first beat.
    bus.out_ready = 1'b0;
    send_vec(16'h0124, 1'b0);
    check("t4_idx_c0", bus.out_idx, 8);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t4_stall_idx", bus.out_idx, 8);
      check("t4_stall_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    wait_drain();

    // 5: full vector, no gaps; a request offered mid-scan is ignored.
    send_vec(16'hFFFF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("t5_no_gap", bus.out_valid, 1);
      if (i == 4) begin
        check("t5_in_ready_busy", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_vec   = 16'h0001;
      end
      if (i == 5) bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // 6: reset after the first beat; remaining indices are discarded.
    send_vec(16'h00F0, 1'b0);
    check("t6_first_idx", bus.out_idx, 7);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_in_ready", bus.in_ready, 1);
    check("t6_rst_busy", bus.busy, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    send_vec(16'h0002, 1'b0);
    check("t6_single_idx", bus.out_idx, 1);
    check("t6_single_last", bus.out_last, 1);
    wait_drain();

    // Randomized vectors with random consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: begin v = 16'h0001; v = v << $urandom_range(0, 15); end
        2: v = 16'h0000;
        3: v = 16'hFFFF ^ (16'h0001 << $urandom_range(0, 15));
        default: v = 16'($urandom);
      endcase
      send_vec(v, 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    wait_drain();

    // 32-bit build: top bit only.
    bus32.in_vec   = 32'h8000_0000;
    bus32.in_valid = 1'b1;
    check("w32_in_ready", bus32.in_ready, 1);
    tick();
    bus32.in_valid = 1'b0;
    check("w32_out_valid", bus32.out_valid, 1);
    check("w32_out_idx", bus32.out_idx, 31);
    check("w32_out_last", bus32.out_last, 1);
    check("w32_out_count", bus32.out_count, 1);
    tick();
    check("w32_bubble", bus32.out_valid, 0);
    check("w32_idle", bus32.in_ready, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
